// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    localparam logic ORDER_MSB = 1'b1;
    localparam logic ORDER_LSB = 1'b0;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Loadable bidirectional shift register with bit counter and last-bit detect.
// The presented bit is held in its own flop so the serial output is registered.
module piso_shift_core
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             load_order_i,
    input  logic             shift_i,
    input  logic             clear_i,
    output logic             bit_o,
    output logic             last_o
);

    localparam int unsigned CntW = cnt_w(WIDTH);

    logic [WIDTH-1:0] sr_q, sr_d, src;
    logic             order_q, order_d, ord;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             last_q, last_d;

    always_comb begin
        src     = load_i ? load_data_i : sr_q;
        ord     = load_i ? load_order_i : order_q;
        sr_d    = sr_q;
        order_d = order_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        last_d  = last_q;
        // A load presents the first bit at once; the register keeps the remainder.
        if (load_i || (shift_i && !clear_i)) begin
            order_d = ord;
            bit_d   = (ord == ORDER_MSB) ? src[WIDTH-1] : src[0];
            sr_d    = (ord == ORDER_MSB) ? (src << 1) : (src >> 1);
            cnt_d   = load_i ? '0 : cnt_q + 1'b1;
            last_d  = !load_i && (cnt_q == CntW'(WIDTH - 2));
        end else if (clear_i) begin
            sr_d    = '0;
            order_d = ORDER_LSB;
            cnt_d   = '0;
            bit_d   = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q    <= '0;
            order_q <= ORDER_LSB;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            order_q <= order_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
        end
    end

    assign bit_o  = bit_q;
    assign last_o = last_q;

endmodule

// File: rtl/piso_serializer.sv
// Valid/ready word serializer: handshake, one-word holding buffer and control FSM
// around piso_shift_core. Back-to-back words stream with no idle cycle.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             pi_valid,
    output logic             pi_ready,
    input  logic             msb_first,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             so_valid_q;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_order_q, hold_order_d;
    logic             hold_valid_q, hold_valid_d;

    logic             accept;
    logic             core_load, core_from_hold, core_shift, core_clear, core_last;
    logic [WIDTH-1:0] core_data;
    logic             core_order;

    assign pi_ready = !hold_valid_q && !rst;
    assign accept   = pi_valid && pi_ready;

    always_comb begin
        state_d        = state_q;
        hold_data_d    = hold_data_q;
        hold_order_d   = hold_order_q;
        hold_valid_d   = hold_valid_q;
        core_load      = 1'b0;
        core_from_hold = 1'b0;
        core_shift     = 1'b0;
        core_clear     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    core_load = 1'b1;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (core_last) begin
                    // Buffered word wins; otherwise a same-edge accept bypasses the buffer.
                    if (hold_valid_q) begin
                        core_load      = 1'b1;
                        core_from_hold = 1'b1;
                        hold_valid_d   = 1'b0;
                    end else if (accept) begin
                        core_load = 1'b1;
                    end else begin
                        core_clear = 1'b1;
                        state_d    = StIdle;
                    end
                end else begin
                    core_shift = 1'b1;
                    if (accept) begin
                        hold_data_d  = pi;
                        hold_order_d = msb_first;
                        hold_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign core_data  = core_from_hold ? hold_data_q : pi;
    assign core_order = core_from_hold ? hold_order_q : msb_first;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            so_valid_q   <= 1'b0;
            hold_data_q  <= '0;
            hold_order_q <= ORDER_LSB;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            so_valid_q   <= (state_d == StShift);
            hold_data_q  <= hold_data_d;
            hold_order_q <= hold_order_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    piso_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .load_i      (core_load),
        .load_data_i (core_data),
        .load_order_i(core_order),
        .shift_i     (core_shift),
        .clear_i     (core_clear),
        .bit_o       (so),
        .last_o      (core_last)
    );

    assign so_valid = so_valid_q;
    assign so_last  = core_last;
    assign busy     = (state_q == StShift) || hold_valid_q;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready word interface, per-word bit-order selection and a one-word holding buffer. Back-to-back words stream out with no idle cycle between them. It replaces the fixed 4-bit load-driven PISO as the serial transmit stage feeding bit-serial links and shift-register chains elsewhere in the design.

## Interface
- WIDTH, 8, bits per parallel word; minimum 2.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- pi  input  WIDTH  parallel word; sampled on handshake.
- pi_valid  input  1  word on pi is offered.
- pi_ready  output  1  block can take a word this cycle.
- msb_first  input  1  bit order for the offered word; sampled with pi (1 = bit WIDTH-1 first, 0 = bit 0 first).
- so  output  1  serial data bit, registered.
- so_valid  output  1  so carries a word bit this cycle.
- so_last  output  1  final bit of the current word.
- busy  output  1  shifter or holding buffer is occupied.

## Operation
- Handshake: the word is accepted on a rising edge where pi_valid && pi_ready. pi_ready = !hold_valid && !rst (combinational from registered state only; never from pi_valid).
- Storage:
  - Shifter: shift_reg[WIDTH], order bit, bit counter cnt (0..WIDTH-1) and state.
  - Holding buffer: hold_data, hold_order, hold_valid.
- States:
  - IDLE: so_valid=0. An accepted word loads the shifter directly; next state is SHIFT with cnt=0.
  - SHIFT: one bit is presented per cycle and cnt increments. At cnt==WIDTH-1 (so_last=1), on the next edge:
    - if hold_valid: load the shifter from the buffer, clear hold_valid, cnt=0, stay in SHIFT;
    - else if a word is accepted that same edge: load it straight into the shifter (bypass), stay in SHIFT;
    - else go to IDLE.
  - A word accepted while in SHIFT with cnt<WIDTH-1 goes into the holding buffer.
- Output bit:
  - MSB-first: so = shift_reg[WIDTH-1], shift left.
  - LSB-first: so = shift_reg[0], shift right.
  - The order latched with the word applies to all of its bits. Changing msb_first mid-word has no effect.
- so is 0 whenever so_valid=0.
- busy = (state==SHIFT) || hold_valid.
- Reset, synchronous, dominates all other inputs: state=IDLE, cnt=0, hold_valid=0, shift_reg=0, so=0, so_valid=0, so_last=0, busy=0, pi_ready=0 while rst is high. A word in flight and a buffered word are discarded. A handshake in the reset cycle is ignored.

## Timing
- Latency: word accepted at edge k, idle shifter → first bit valid in the cycle after edge k; last bit in the cycle after edge k+WIDTH-1.
- Sustained throughput: one word per WIDTH cycles. so_valid stays continuously high across word boundaries when the buffer or the bypass supplies the next word.
- The buffer fills at most once per word. pi_ready drops the cycle after a buffered accept and rises the cycle after the buffer drains into the shifter.
- Simultaneous last-bit and accept with the buffer empty uses the bypass; the word is not buffered.
- so_last is high for exactly one cycle per word, aligned with the final so bit.

## Structure
- Package piso_pkg:
  - state typedef (IDLE, SHIFT);
  - function cnt_w(WIDTH) = $clog2(WIDTH);
  - constants ORDER_MSB=1'b1 and ORDER_LSB=1'b0.
- One sub-module, piso_shift_core: the loadable bidirectional shift register with cnt and last-bit detect.
- The top level holds the handshake, the holding buffer and the FSM.

## Test plan
- WIDTH=4, rst for 2 cycles, then offer pi=4'b1010, msb_first=1 → so=1,0,1,0 on consecutive cycles; so_last on the 4th; then so_valid=0, busy=0.
- WIDTH=4, pi=4'b1101, msb_first=0 → so=1,0,1,1; so_last on the 4th bit.
- WIDTH=8, pi_valid held high with words 8'hA5 then 8'h3C, MSB-first:
  - 16 contiguous so_valid cycles: 10100101 then 00111100;
  - pi_ready low from the cycle after the second accept until the buffer reloads the shifter.
- WIDTH=8, second word offered exactly on the last-bit cycle with the buffer empty → accepted via bypass, no gap, pi_ready stays 1.
- Assert rst at bit 3 of 8'hFF while a word is buffered:
  - next cycle so=0, so_valid=0, busy=0, pi_ready=0;
  - after release pi_ready=1 and no stale bits are emitted.
- Toggle msb_first mid-word for WIDTH=4, pi=4'b0001 loaded MSB-first → output stays 0,0,0,1.
